// File: rtl/fnd_scan_controller.sv
// Multi-digit common-anode seven-segment scan controller: a binary value taken over a
// valid/ready handshake is converted to BCD by shift-add-3, then scanned digit by digit.
module fnd_scan_controller #(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 14,
    parameter int SYS_CLK_HZ = 100_000_000,
    parameter int SCAN_HZ    = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  blank_lz,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    input  logic                  enable,
    output logic                  overflow,
    output logic [NUM_DIGITS-1:0] fnd_digit,
    output logic [7:0]            fnd_data
);

    localparam int SCAN_DIV = SYS_CLK_HZ / SCAN_HZ;
    localparam int BCD_W    = 4 * NUM_DIGITS;
    localparam int CNT_W    = $clog2(DATA_W + 1);
    localparam int TICK_W   = $clog2(SCAN_DIV);
    localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int k = 0; k < n; k++) p = p * 64'd10;
        return p;
    endfunction

    localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;

    // Segment pattern {g,f,e,d,c,b,a}, active low; dp is added at the output register.
    function automatic logic [6:0] dec7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [DATA_W-1:0]  shift_reg, shift_next;
    logic [BCD_W-1:0]   bcd_reg, bcd_next;
    logic [BCD_W-1:0]   disp_reg, disp_next;
    logic               ovf_pend_reg, ovf_pend_next;
    logic               overflow_reg, overflow_next;
    logic [BCD_W-1:0]   bcd_adj;
    logic [TICK_W-1:0]  tick_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               tick;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                        bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            shift_reg    <= '0;
            bcd_reg      <= '0;
            disp_reg     <= '0;
            ovf_pend_reg <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            shift_reg    <= shift_next;
            bcd_reg      <= bcd_next;
            disp_reg     <= disp_next;
            ovf_pend_reg <= ovf_pend_next;
            overflow_reg <= overflow_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        shift_next    = shift_reg;
        bcd_next      = bcd_reg;
        disp_next     = disp_reg;
        ovf_pend_next = ovf_pend_reg;
        overflow_next = overflow_reg;
        in_ready      = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shift_next    = in_data;
                    cnt_next      = CNT_W'(DATA_W);
                    bcd_next      = '0;
                    ovf_pend_next = (64'(in_data) > MAX_VAL);
                    state_next    = SHIFT;
                end
            end
            SHIFT: begin
                // Digits above NUM_DIGITS fall off the top; overflow flags that case.
                bcd_next   = {bcd_adj[BCD_W-2:0], shift_reg[DATA_W-1]};
                shift_next = shift_reg << 1;
                cnt_next   = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) state_next = LOAD;
            end
            LOAD: begin
                disp_next     = bcd_reg;
                overflow_next = ovf_pend_reg;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign overflow = overflow_reg;
    assign tick     = (tick_reg == TICK_W'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_reg <= '0;
            idx_reg  <= '0;
        end else begin
            tick_reg <= tick ? '0 : tick_reg + TICK_W'(1);
            if (tick) idx_reg <= (idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
        end
    end

    logic [6:0]            seg7 [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] digit_sel;

    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
            logic upper_nz;
            logic blank;
            // A digit is a leading zero when it and every digit above it are zero.
            assign upper_nz = |disp_reg[BCD_W-1:4*gi];
            assign blank    = blank_lz && (gi != 0) && !upper_nz;
            assign seg7[gi] = overflow_reg ? 7'h3F :
                              blank        ? 7'h7F : dec7(disp_reg[4*gi +: 4]);
            assign digit_sel[gi] = (idx_reg == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            fnd_digit <= '1;
            fnd_data  <= 8'hFF;
        end else begin
            fnd_digit <= ~digit_sel;
            fnd_data  <= {~dp_mask[idx_reg], seg7[idx_reg]};
        end
    end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller: accepted values go to a scoreboard queue and are
// compared, digit by digit, against a decimal model once the display updates.
module tb_fnd_scan_controller;

    localparam int ND   = 4;
    localparam int DW   = 14;
    localparam int SDIV = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          blank_lz = 1'b0;
    logic [ND-1:0] dp_mask = '0;
    logic          enable = 1'b1;
    logic          overflow;
    logic [ND-1:0] fnd_digit;
    logic [7:0]    fnd_data;

    fnd_scan_controller #(
        .NUM_DIGITS(ND), .DATA_W(DW), .SYS_CLK_HZ(100), .SCAN_HZ(10)
    ) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .blank_lz(blank_lz), .dp_mask(dp_mask), .enable(enable),
        .overflow(overflow), .fnd_digit(fnd_digit), .fnd_data(fnd_data)
    );

    always #5 clk = ~clk;

    // Number of non-reset edges seen; the scan position is a pure function of it.
    int cyc;
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    int         n_tests = 0;
    int         n_fail  = 0;
    int         sb_q[$];
    int         cur_val = 0;
    int         acc_cyc = 0;
    logic [7:0] seg_tab [10];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] exp_code(int v, int i, logic blz, logic [ND-1:0] dp);
        int p;
        logic [7:0] s;
        p = 1;
        for (int j = 0; j < i; j++) p = p * 10;
        if (v > 9999)                      s = 8'hBF;
        else if (blz && i != 0 && v < p)   s = 8'hFF;
        else                               s = seg_tab[(v / p) % 10];
        s[7] = ~dp[i];
        return s;
    endfunction

    function automatic int cur_idx();
        return ((cyc - 1) / SDIV) % ND;
    endfunction

    task automatic check_frame(input string tag, input int v);
        int di;
        logic [ND-1:0] ed;
        for (int k = 0; k < ND * SDIV; k++) begin
            @(posedge clk);
            @(negedge clk);
            di = cur_idx();
            ed = ~(ND'(1) << di);
            chk({tag, "_digit"}, 32'(fnd_digit), 32'(ed));
            chk({tag, "_seg"}, 32'(fnd_data), 32'(exp_code(v, di, blank_lz, dp_mask)));
        end
        chk({tag, "_ovf"}, 32'(overflow), 32'(v > 9999));
        $display("[TB] frame %s value=%0d checked", tag, v);
    endtask

    // Drive a value and return at the negedge after the accepting edge.
    task automatic accept(input int v);
        int t;
        @(negedge clk);
        in_data  = DW'(v);
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", 32'(in_ready), 32'd1);
        @(posedge clk);
        sb_q.push_back(v);
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
        $display("[TB] accept value=%0d at cycle %0d", v, acc_cyc);
    endtask

    // Wait for the conversion to finish, check its latency and that the old value is
    // still on the pins in that cycle, then take the new expected value off the queue.
    task automatic finish_conv(input string tag);
        int t;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_busy_cycles"}, 32'(cyc - acc_cyc), 32'(DW + 1));
        chk({tag, "_old_seg"}, 32'(fnd_data), 32'(exp_code(cur_val, cur_idx(), blank_lz, dp_mask)));
        if (sb_q.size() > 0) cur_val = sb_q.pop_front();
        chk({tag, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
    endtask

    int acc_t[$];

    initial begin
        seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_digit", 32'(fnd_digit), 32'hF);
        chk("rst_data", 32'(fnd_data), 32'hFF);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        check_frame("boot", 0);

        accept(1234);
        finish_conv("v1234");
        check_frame("v1234", cur_val);

        blank_lz = 1'b1;
        accept(7);
        finish_conv("v7");
        check_frame("v7_blz", cur_val);
        blank_lz = 1'b0;
        check_frame("v7_noblz", cur_val);
        blank_lz = 1'b1;
        accept(0);
        finish_conv("v0");
        check_frame("v0_blz", cur_val);
        accept(12345);
        finish_conv("v12345");
        check_frame("ovf_blz", cur_val);
        blank_lz = 1'b0;
        accept(42);
        finish_conv("v42");
        check_frame("v42", cur_val);

        // A second request during conversion must be dropped.
        accept(1234);
        repeat (3) @(negedge clk);
        in_data  = DW'(5678);
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        finish_conv("ignored");
        check_frame("ignored", cur_val);

        dp_mask = 4'b0100;
        check_frame("dp", cur_val);
        dp_mask = '0;

        repeat (13) @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("en_off_digit", 32'(fnd_digit), 32'hF);
        chk("en_off_data", 32'(fnd_data), 32'hFF);
        enable = 1'b1;

        // Reset in the middle of SHIFT discards the conversion.
        accept(7);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_digit", 32'(fnd_digit), 32'hF);
        chk("midrst_data", 32'(fnd_data), 32'hFF);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        sb_q.delete();
        cur_val = 0;
        check_frame("midrst", cur_val);

        // in_valid held high: one accept every DW + 2 cycles.
        @(negedge clk);
        in_data  = DW'(5);
        in_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (in_ready) begin
                acc_t.push_back(cyc);
                sb_q.push_back(5);
                $display("[TB] back-to-back accept at cycle %0d", cyc);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("b2b_count", 32'(acc_t.size()), 32'd3);
        if (acc_t.size() >= 2) chk("b2b_gap", 32'(acc_t[1] - acc_t[0]), 32'(DW + 2));
        begin
            int t;
            t = 0;
            while (!in_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            chk("b2b_ready", 32'(in_ready), 32'd1);
        end
        while (sb_q.size() > 0) cur_val = sb_q.pop_front();
        check_frame("b2b", cur_val);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
